edge_detector: RTL and testbench
================================

EDGE_DETECTOR -- requirements
Module: edge_detector

Interface
REQ-001 Parameter: IMG_WIDTH, default 640, pixels per line scanned per operation (>=1).
REQ-002 Parameter: IMG_HEIGHT, default 480, lines per frame scanned per operation (>=1).
REQ-003 Port: clk  input  1  system clock; the block has one clock and all state changes on its rising edge.
REQ-004 Port: rst  input  1  reset; asynchronous, active-high.
REQ-005 Port: req  input  1  operation request from host, level, 4-phase handshake with ack.
REQ-006 Port: ack  output  1  operation complete; held until req falls.
REQ-007 Port: busy  output  1  high while an operation is in progress.
REQ-008 Port: intial_de_req  output  1  request to drawing engine for initial frame setup.
REQ-009 Port: intial_de_ack  input  1  drawing-engine acknowledge; treated as a level and may stay high indefinitely.

Function
REQ-010 The FSM SHALL have states IDLE, INIT, SCAN and DONE; all outputs SHALL be registered.
REQ-011 IDLE: ack=0, busy=0, intial_de_req=0; req sampled 1 -> INIT.
REQ-012 INIT: busy=1, intial_de_req=1; intial_de_req rises on the same edge that enters INIT, one cycle after req is sampled high.
REQ-013 INIT: intial_de_req held high until intial_de_ack is sampled 1 on a rising edge; that edge -> SCAN, intial_de_req=0.
REQ-014 intial_de_ack SHALL be ignored outside INIT; an ack already high on INIT entry completes the handshake on the first INIT edge.
REQ-015 SCAN: busy=1; internal counters x (ceil(log2 IMG_WIDTH) bits) and y (ceil(log2 IMG_HEIGHT) bits) start at 0,0 on SCAN entry.
REQ-016 SCAN: each cycle x increments; at x=IMG_WIDTH-1, x wraps to 0 and y increments.
REQ-017 SCAN SHALL last exactly IMG_WIDTH*IMG_HEIGHT cycles; the edge that processes (IMG_WIDTH-1, IMG_HEIGHT-1) -> DONE.
REQ-018 DONE: ack=1, busy=0; req sampled 0 -> IDLE, ack=0.
REQ-019 req falling during INIT or SCAN SHALL NOT abort; the operation completes and DONE then holds ack one cycle before IDLE.
REQ-020 req held high continuously after DONE SHALL NOT start a new operation; a new operation requires req low then high again via IDLE.
REQ-021 busy and ack SHALL never be high simultaneously.
REQ-022 Degenerate 1x1 frame: SCAN lasts 1 cycle.

Reset
REQ-023 rst=1 SHALL immediately, without waiting for clk, force IDLE: ack=0, busy=0, intial_de_req=0, x=y=0.
REQ-024 Reset asserted mid-operation (any state) SHALL abandon the operation; after release, the block waits in IDLE for req.
REQ-025 On rst release, req already high SHALL start an operation on the first rising edge.

Verification
REQ-026 IMG_WIDTH=4, IMG_HEIGHT=3; req=1 at t0, intial_de_ack raised 1 cycle after intial_de_req and held -> intial_de_req high exactly 2 cycles; busy high through INIT plus 12 SCAN cycles; then ack=1, busy=0, with ack held while req stays 1.
REQ-027 From DONE, drop req -> ack=0 next edge, IDLE; raise req again -> second identical operation, including an INIT handshake despite intial_de_ack still high (1 INIT cycle).
REQ-028 intial_de_ack held low for 50 cycles -> intial_de_req stays 1, busy=1, no SCAN progress; ack=0 throughout.
REQ-029 Assert rst during SCAN (x=2, y=1) -> outputs 0 asynchronously; release with req=0 -> stays IDLE.
REQ-030 IMG_WIDTH=IMG_HEIGHT=1; req pulse 1 cycle, intial_de_ack=1 -> INIT 1 cycle, SCAN 1 cycle, ack high 1 cycle then IDLE.

Source files
------------

// File: rtl/edge_detector.sv
// Edge-detector frame sequencer: 4-phase req/ack host handshake, drawing-engine
// init handshake, then a raster scan of IMG_WIDTH x IMG_HEIGHT pixel positions.
// Latency: INIT (>=1 cycle) + IMG_WIDTH*IMG_HEIGHT scan cycles; all outputs registered.

module edge_detector #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  output logic ack,
  output logic busy,
  output logic intial_de_req,
  input  logic intial_de_ack
);

  // A 1-pixel dimension still needs a 1-bit counter to stay a legal vector.
  localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          r_state;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic            r_ack;
  logic            r_busy;
  logic            r_de_req;

  logic            w_x_last;
  logic            w_y_last;

  assign w_x_last = (r_x == X_LAST);
  assign w_y_last = (r_y == Y_LAST);

  assign ack           = r_ack;
  assign busy          = r_busy;
  assign intial_de_req = r_de_req;

  // Sequencer state, scan counters and registered outputs, updated together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_x      <= '0;
      r_y      <= '0;
      r_ack    <= 1'b0;
      r_busy   <= 1'b0;
      r_de_req <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // Only a req seen here starts work; a req still high from the
          // previous operation is absorbed by DONE, so no auto-restart.
          if (req) begin
            r_state  <= INIT;
            r_busy   <= 1'b1;
            r_de_req <= 1'b1;
          end
        end

        INIT: begin
          // Drawing-engine ack is a level; an already-high ack completes
          // the handshake on the first INIT edge.
          if (intial_de_ack) begin
            r_state  <= SCAN;
            r_de_req <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
          end
        end

        SCAN: begin
          // One pixel position per cycle, x fastest; req is not looked at,
          // so a host dropping req cannot abort the scan.
          if (w_x_last) begin
            r_x <= '0;
            if (w_y_last) begin
              r_y     <= '0;
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_ack   <= 1'b1;
            end else begin
              r_y <= r_y + YW'(1);
            end
          end else begin
            r_x <= r_x + XW'(1);
          end
        end

        DONE: begin
          // Hold ack until the host releases req (at least one cycle).
          if (!req) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
          end
        end

        default: begin
          r_state  <= IDLE;
          r_ack    <= 1'b0;
          r_busy   <= 1'b0;
          r_de_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edge_detector.sv
// Directed bench for edge_detector: a 4x3 instance for the main sequences and
// a 1x1 instance for the degenerate frame; every check uses hand-computed
// expectations against the cycle-by-cycle handshake timing.

module tb_edge_detector;

  logic clk;
  logic rst;

  logic req,  ack,  busy,  de_req,  de_ack;
  logic req1, ack1, busy1, de_req1, de_ack1;

  int checks   = 0;
  int failures = 0;

  edge_detector #(.IMG_WIDTH(4), .IMG_HEIGHT(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .ack           (ack),
    .busy          (busy),
    .intial_de_req (de_req),
    .intial_de_ack (de_ack)
  );

  edge_detector #(.IMG_WIDTH(1), .IMG_HEIGHT(1)) dut1 (
    .clk           (clk),
    .rst           (rst),
    .req           (req1),
    .ack           (ack1),
    .busy          (busy1),
    .intial_de_req (de_req1),
    .intial_de_ack (de_ack1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
  endtask

  // Advance one rising edge, land 1 time unit after it, and confirm that
  // busy and ack are never high together on either instance.
  task automatic tick();
    @(posedge clk);
    #1;
    check("busy_ack_excl", busy & ack, 1'b0);
    check("busy_ack_excl_1x1", busy1 & ack1, 1'b0);
  endtask

  task automatic outs(input string tag, input logic e_ack, input logic e_busy, input logic e_dreq);
    check({tag, "_ack"},  ack,    e_ack);
    check({tag, "_busy"}, busy,   e_busy);
    check({tag, "_dreq"}, de_req, e_dreq);
  endtask

  task automatic outs1(input string tag, input logic e_ack, input logic e_busy, input logic e_dreq);
    check({tag, "_ack"},  ack1,    e_ack);
    check({tag, "_busy"}, busy1,   e_busy);
    check({tag, "_dreq"}, de_req1, e_dreq);
  endtask

  initial begin
    rst     = 1'b1;
    req     = 1'b0;
    de_ack  = 1'b0;
    req1    = 1'b0;
    de_ack1 = 1'b0;

    // Reset state
    tick();
    tick();
    outs("reset", 1'b0, 1'b0, 1'b0);
    outs1("reset_1x1", 1'b0, 1'b0, 1'b0);

    // Operation 1: req already high on reset release starts on first edge
    rst = 1'b0;
    req = 1'b1;
    tick();
    outs("op1_init_c1", 1'b0, 1'b1, 1'b1);
    tick();
    outs("op1_init_c2", 1'b0, 1'b1, 1'b1);
    de_ack = 1'b1;
    tick();
    outs("op1_scan_entry", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 11; i++) begin
      tick();
      outs("op1_scan", 1'b0, 1'b1, 1'b0);
    end
    tick();
    outs("op1_done", 1'b1, 1'b0, 1'b0);
    // req held high: ack held, no new operation
    for (int i = 0; i < 3; i++) begin
      tick();
      outs("op1_hold", 1'b1, 1'b0, 1'b0);
    end
    req = 1'b0;
    tick();
    outs("op1_release", 1'b0, 1'b0, 1'b0);
    tick();
    outs("idle_gap", 1'b0, 1'b0, 1'b0);

    // Operation 2: de_ack still high -> 1-cycle INIT; req dropped mid-operation
    req = 1'b1;
    tick();
    outs("op2_init", 1'b0, 1'b1, 1'b1);
    req = 1'b0;
    tick();
    outs("op2_scan_entry", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 11; i++) begin
      tick();
      outs("op2_scan", 1'b0, 1'b1, 1'b0);
    end
    tick();
    outs("op2_done", 1'b1, 1'b0, 1'b0);
    tick();
    outs("op2_auto_idle", 1'b0, 1'b0, 1'b0);

    // Operation 3: drawing engine stalls 50 cycles
    de_ack = 1'b0;
    req    = 1'b1;
    tick();
    outs("op3_init", 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 50; i++) begin
      tick();
      outs("op3_stall", 1'b0, 1'b1, 1'b1);
    end
    de_ack = 1'b1;
    req    = 1'b0;
    tick();
    outs("op3_scan_entry", 1'b0, 1'b1, 1'b0);
    // Six processed positions bring the scan to x=2, y=1
    for (int i = 0; i < 6; i++) begin
      tick();
      outs("op3_scan", 1'b0, 1'b1, 1'b0);
    end

    // Asynchronous reset mid-scan, away from any clock edge
    #2;
    rst = 1'b1;
    #1;
    outs("async_rst", 1'b0, 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      outs("post_rst_idle", 1'b0, 1'b0, 1'b0);
    end

    // Degenerate 1x1 frame: 1-cycle req pulse, de_ack high
    de_ack1 = 1'b1;
    req1    = 1'b1;
    tick();
    outs1("d1_init", 1'b0, 1'b1, 1'b1);
    req1 = 1'b0;
    tick();
    outs1("d1_scan", 1'b0, 1'b1, 1'b0);
    tick();
    outs1("d1_done", 1'b1, 1'b0, 1'b0);
    tick();
    outs1("d1_idle", 1'b0, 1'b0, 1'b0);
    tick();
    outs1("d1_idle2", 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
